// File: rtl/usb_port_scheduler_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// +------------------------------------------------------------------------+
// | usb_port_scheduler_pkg                                                 |
// | Shared types and constants for the USB two-port scheduler.             |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
package usb_port_scheduler_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SWITCH = 3'd1,
        ST_READ   = 3'd2,
        ST_WAIT   = 3'd3,
        ST_DONE   = 3'd4,
        ST_WRITE  = 3'd5
    } sched_state_t;

    localparam logic PORT0   = 1'b0;
    localparam logic PORT1   = 1'b1;
    localparam int   TIMER_W = 16;

    // Round-robin pick starting at ptr: bit1 = a port is available, bit0 = that port.
    function automatic logic [1:0] rr_pick(input logic [1:0] en, input logic ptr);
        logic [1:0] res;
        res = 2'b00;
        if (en[ptr]) begin
            res = {1'b1, ptr};
        end else if (en[~ptr]) begin
            res = {1'b1, ~ptr};
        end
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/usb_sched_timer.sv
`timescale 1ns/1ps
`default_nettype none
// +------------------------------------------------------------------------+
// | usb_sched_timer                                                        |
// | Loadable down-counter shared by the settle and read-timeout phases.    |
// | Counts down to zero and rests there; zero_o flags expiry.              |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module usb_sched_timer #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    output logic             zero_o
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] count_q;

    // Load has priority over clear; otherwise decrement until zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else if (load_i) begin
            count_q <= load_val_i;
        end else if (clear_i) begin
            count_q <= '0;
        end else if (count_q != '0) begin
            count_q <= count_q - ONE;
        end
    end

    assign zero_o = (count_q == '0);

endmodule
`default_nettype wire

// File: rtl/usb_port_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
// +------------------------------------------------------------------------+
// | usb_port_scheduler                                                     |
// | Drives the select of the two-port switcher: round-robin reads with a   |
// | bounded wait, priority writes, settle time after every select update.  |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module usb_port_scheduler
    import usb_port_scheduler_pkg::*;
#(
    parameter int SETTLE_CYCLES  = 2,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] ch_en,
    output logic       sel,
    output logic       rd,
    output logic       wr,
    input  logic       drdy,
    input  logic [7:0] d,
    input  logic       wr_req,
    input  logic       wr_ch,
    output logic       wr_ack,
    output logic       out_valid,
    output logic [7:0] out_data,
    output logic       out_ch,
    output logic       timeout_err,
    output logic       timeout_ch
);

    // The timer reads zero on the last cycle of a phase, so load N-1.
    localparam logic [TIMER_W-1:0] SETTLE_LOAD  = TIMER_W'(SETTLE_CYCLES - 1);
    localparam logic [TIMER_W-1:0] TIMEOUT_LOAD = TIMER_W'(TIMEOUT_CYCLES - 1);

    sched_state_t       state_q;
    logic               tgt_q;
    logic               op_wr_q;
    logic               rr_ptr_q;
    logic               sel_q;
    logic               rd_q;
    logic               wr_q;
    logic               wr_ack_q;
    logic               out_valid_q;
    logic [7:0]         out_data_q;
    logic               out_ch_q;
    logic               timeout_err_q;
    logic               timeout_ch_q;

    logic [1:0]         arb_d;
    logic               start_d;
    logic               tmr_load_d;
    logic               tmr_clear_d;
    logic [TIMER_W-1:0] tmr_val_d;
    logic               tmr_zero;

    assign arb_d       = rr_pick(ch_en, rr_ptr_q);
    assign start_d     = (state_q == ST_IDLE) && (wr_req || arb_d[1]);
    assign tmr_clear_d = (state_q == ST_IDLE) && !start_d;

    // Timer loads: settle time when a transaction starts, timeout when a read misses drdy.
    always_comb begin
        tmr_load_d = 1'b0;
        tmr_val_d  = SETTLE_LOAD;
        if (start_d) begin
            tmr_load_d = 1'b1;
            tmr_val_d  = SETTLE_LOAD;
        end else if ((state_q == ST_READ) && !drdy) begin
            tmr_load_d = 1'b1;
            tmr_val_d  = TIMEOUT_LOAD;
        end
    end

    usb_sched_timer #(
        .WIDTH (TIMER_W)
    ) u_timer (
        .clk        (clk),
        .reset      (reset),
        .clear_i    (tmr_clear_d),
        .load_i     (tmr_load_d),
        .load_val_i (tmr_val_d),
        .zero_o     (tmr_zero)
    );

    // Sequencer: arbitration, settle, strobes, capture and timeout; every output registered here.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            tgt_q         <= PORT0;
            op_wr_q       <= 1'b0;
            rr_ptr_q      <= PORT0;
            sel_q         <= PORT0;
            rd_q          <= 1'b0;
            wr_q          <= 1'b0;
            wr_ack_q      <= 1'b0;
            out_valid_q   <= 1'b0;
            out_data_q    <= 8'h00;
            out_ch_q      <= PORT0;
            timeout_err_q <= 1'b0;
            timeout_ch_q  <= PORT0;
        end else begin
            rd_q          <= 1'b0;
            wr_q          <= 1'b0;
            wr_ack_q      <= 1'b0;
            out_valid_q   <= 1'b0;
            timeout_err_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    // Pending writes beat polling; sel only ever moves here.
                    if (wr_req) begin
                        tgt_q   <= wr_ch;
                        sel_q   <= wr_ch;
                        op_wr_q <= 1'b1;
                        state_q <= ST_SWITCH;
                    end else if (arb_d[1]) begin
                        tgt_q   <= arb_d[0];
                        sel_q   <= arb_d[0];
                        op_wr_q <= 1'b0;
                        state_q <= ST_SWITCH;
                    end
                end
                ST_SWITCH: begin
                    if (tmr_zero) begin
                        if (op_wr_q) begin
                            wr_q     <= 1'b1;
                            wr_ack_q <= 1'b1;
                            state_q  <= ST_WRITE;
                        end else begin
                            rd_q    <= 1'b1;
                            state_q <= ST_READ;
                        end
                    end
                end
                ST_READ: begin
                    if (drdy) begin
                        out_data_q  <= d;
                        out_ch_q    <= tgt_q;
                        out_valid_q <= 1'b1;
                        state_q     <= ST_DONE;
                    end else begin
                        state_q <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    // Data arriving on the expiry cycle still counts as a success.
                    if (drdy) begin
                        out_data_q  <= d;
                        out_ch_q    <= tgt_q;
                        out_valid_q <= 1'b1;
                        state_q     <= ST_DONE;
                    end else if (tmr_zero) begin
                        timeout_err_q <= 1'b1;
                        timeout_ch_q  <= tgt_q;
                        rr_ptr_q      <= ~tgt_q;
                        state_q       <= ST_IDLE;
                    end
                end
                ST_DONE: begin
                    rr_ptr_q <= ~tgt_q;
                    state_q  <= ST_IDLE;
                end
                ST_WRITE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign sel         = sel_q;
    assign rd          = rd_q;
    assign wr          = wr_q;
    assign wr_ack      = wr_ack_q;
    assign out_valid   = out_valid_q;
    assign out_data    = out_data_q;
    assign out_ch      = out_ch_q;
    assign timeout_err = timeout_err_q;
    assign timeout_ch  = timeout_ch_q;

endmodule
`default_nettype wire

// File: tb/tb_usb_port_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_usb_port_scheduler                                                  |
// | Randomized transaction stimulus with a queue-based scoreboard for the  |
// | USB two-port scheduler.                                                |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module tb_usb_port_scheduler;

    localparam int S      = 2;
    localparam int T      = 8;
    localparam int NTRANS = 200;
    localparam int MAXCYC = 16384;

    typedef enum int {EV_RD, EV_WR, EV_OV, EV_TO} ev_kind_t;
    typedef struct {
        ev_kind_t   kind;
        int         cyc;
        logic       ch;
        logic [7:0] data;
    } ev_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] ch_en;
    logic       sel;
    logic       rd;
    logic       wr;
    logic       drdy;
    logic [7:0] d;
    logic       wr_req;
    logic       wr_ch;
    logic       wr_ack;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_ch;
    logic       timeout_err;
    logic       timeout_ch;

    int  cyc = 0;
    int  n_cmp = 0;
    int  n_err = 0;
    bit  mon_en = 1'b0;
    ev_t exp_q[$];
    bit  exp_sel_at[MAXCYC];
    bit  exp_sel_v[MAXCYC];

    usb_port_scheduler #(
        .SETTLE_CYCLES  (S),
        .TIMEOUT_CYCLES (T)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .ch_en       (ch_en),
        .sel         (sel),
        .rd          (rd),
        .wr          (wr),
        .drdy        (drdy),
        .d           (d),
        .wr_req      (wr_req),
        .wr_ch       (wr_ch),
        .wr_ack      (wr_ack),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .out_ch      (out_ch),
        .timeout_err (timeout_err),
        .timeout_ch  (timeout_ch)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_ev(input ev_kind_t k, input int c, input logic ch, input logic [7:0] data);
        ev_t e;
        e.kind = k;
        e.cyc  = c;
        e.ch   = ch;
        e.data = data;
        exp_q.push_back(e);
    endtask

    task automatic mark_sel(input int from, input int to, input logic v);
        for (int k = from; k <= to; k++) begin
            if (k < MAXCYC) begin
                exp_sel_at[k] = v;
                exp_sel_v[k]  = 1'b1;
            end
        end
    endtask

    task automatic expect_ev(input ev_kind_t k, input logic ch, input logic [7:0] data);
        ev_t e;
        n_cmp++;
        if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_event: %s ch=%0d data=%02h at cycle %0d, nothing expected",
                     k.name(), ch, data, cyc);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != k || e.cyc != cyc || e.ch != ch || e.data != data) begin
                n_err++;
                $display("FAIL event: got %s ch=%0d data=%02h at cycle %0d, expected %s ch=%0d data=%02h at cycle %0d",
                         k.name(), ch, data, cyc, e.kind.name(), e.ch, e.data, e.cyc);
            end
        end
    endtask

    task automatic wait_until(input int k);
        while (cyc < k) @(negedge clk);
    endtask

    // Monitor: compare every strobe against the scoreboard, and sel every cycle.
    always @(negedge clk) begin
        if (mon_en) begin
            if (cyc < MAXCYC && exp_sel_v[cyc]) chk("sel_hold", sel, exp_sel_at[cyc]);
            if (rd) begin
                chk("rd_wr_exclusive", wr, 0);
                expect_ev(EV_RD, sel, 8'h00);
            end
            if (wr) expect_ev(EV_WR, sel, 8'h00);
            if (wr || wr_ack) chk("wr_ack_with_wr", wr_ack, wr);
            if (out_valid) expect_ev(EV_OV, out_ch, out_data);
            if (timeout_err) expect_ev(EV_TO, timeout_ch, 8'h00);
        end
    end

    // Stimulus and transaction-level reference model.
    initial begin
        int   c_dec;
        int   n;
        int   r_cyc;
        int   lat;
        int   nxt;
        int   kw;
        int   scr;
        int   guard;
        logic rr;
        logic cur_sel;
        logic p;
        bit   found;
        bit   wr_pend;
        logic wr_tgt;
        logic [7:0] data;

        reset = 1'b1; ch_en = 2'b00; drdy = 1'b0; d = 8'h00; wr_req = 1'b0; wr_ch = 1'b0;
        wr_pend = 1'b0; wr_tgt = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_sel", sel, 0);
        chk("reset_rd", rd, 0);
        chk("reset_wr", wr, 0);
        chk("reset_wr_ack", wr_ack, 0);
        chk("reset_out_valid", out_valid, 0);
        chk("reset_out_data", out_data, 0);
        chk("reset_out_ch", out_ch, 0);
        chk("reset_timeout_err", timeout_err, 0);
        chk("reset_timeout_ch", timeout_ch, 0);

        reset   = 1'b0;
        c_dec   = cyc;
        rr      = 1'b0;
        cur_sel = 1'b0;
        mark_sel(c_dec, c_dec, 1'b0);
        mon_en  = 1'b1;
        n       = 0;

        while (n < NTRANS || wr_pend) begin
            wait_until(c_dec);
            drdy  = 1'b0;
            d     = 8'($urandom);
            ch_en = (n < NTRANS) ? 2'($urandom) : 2'b00;
            if (!wr_pend && n < NTRANS && $urandom_range(0, 5) == 0) begin
                wr_pend = 1'b1; wr_tgt = 1'($urandom); wr_req = 1'b1; wr_ch = wr_tgt;
            end
            if (wr_pend) begin
                // Write: strobe after the full settle time, pointer untouched.
                r_cyc = c_dec + 1 + S;
                push_ev(EV_WR, r_cyc, wr_tgt, 8'h00);
                mark_sel(c_dec + 1, r_cyc + 1, wr_tgt);
                cur_sel = wr_tgt;
                for (int k = c_dec + 1; k <= r_cyc; k++) begin
                    wait_until(k);
                    drdy = 1'($urandom);
                    d    = 8'($urandom);
                    if ($urandom_range(0, 3) == 0) ch_en = 2'($urandom);
                    if (k == r_cyc) begin
                        wr_req = 1'b0; wr_ch = 1'($urandom); wr_pend = 1'b0;
                    end
                end
                c_dec = r_cyc + 1;
                n++;
            end else begin
                found = 1'b1;
                p     = rr;
                if (ch_en[rr])       p = rr;
                else if (ch_en[!rr]) p = !rr;
                else                 found = 1'b0;
                if (!found) begin
                    mark_sel(c_dec + 1, c_dec + 1, cur_sel);
                    c_dec++;
                    continue;
                end
                // Read: lat = cycles after rd until drdy; beyond T means the port never answers.
                r_cyc = c_dec + 1 + S;
                lat   = $urandom_range(0, T + 2);
                data  = 8'($urandom);
                push_ev(EV_RD, r_cyc, p, 8'h00);
                if (lat <= T) begin
                    push_ev(EV_OV, r_cyc + lat + 1, p, data);
                    nxt = r_cyc + lat + 2;
                end else begin
                    push_ev(EV_TO, r_cyc + T + 1, p, 8'h00);
                    nxt = r_cyc + T + 1;
                end
                rr = !p;
                mark_sel(c_dec + 1, nxt, p);
                cur_sel = p;
                kw  = ($urandom_range(0, 2) == 0) ? int'($urandom_range(c_dec + 1, nxt - 1)) : -1;
                scr = $urandom_range(c_dec + 1, nxt - 1);
                for (int k = c_dec + 1; k < nxt; k++) begin
                    wait_until(k);
                    drdy = 1'b0;
                    d    = 8'($urandom);
                    if (lat <= T && k == r_cyc + lat) begin
                        drdy = 1'b1; d = data;
                    end else if (k < r_cyc || (lat <= T && k == r_cyc + lat + 1)) begin
                        drdy = 1'($urandom);
                    end
                    if (k == scr) ch_en = 2'($urandom);
                    if (k == kw && !wr_pend) begin
                        wr_pend = 1'b1; wr_tgt = 1'($urandom); wr_req = 1'b1; wr_ch = wr_tgt;
                    end
                end
                c_dec = nxt;
                n++;
            end
        end

        wait_until(c_dec);
        ch_en = 2'b00; drdy = 1'b0;
        mark_sel(c_dec + 1, c_dec + 8, cur_sel);
        repeat (6) @(negedge clk);
        chk("scoreboard_drained", exp_q.size(), 0);
        mon_en = 1'b0;

        // Directed: port 0 read, then a port 1 read stuck in WAIT is cut off by reset.
        ch_en = 2'b01; drdy = 1'b1; d = 8'hA5;
        guard = 0;
        while (!out_valid && guard < 40) begin @(negedge clk); guard++; end
        chk("dir_out_valid", out_valid, 1);
        chk("dir_out_data", out_data, 8'hA5);
        chk("dir_out_ch", out_ch, 0);
        ch_en = 2'b11; drdy = 1'b0; d = 8'h00;
        guard = 0;
        while (!rd && guard < 40) begin @(negedge clk); guard++; end
        chk("dir_rd_port1", rd, 1);
        chk("dir_sel_port1", sel, 1);
        repeat (3) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("async_rst_sel", sel, 0);
        chk("async_rst_out_data", out_data, 0);
        chk("async_rst_out_ch", out_ch, 0);
        chk("async_rst_rd", rd, 0);
        chk("async_rst_timeout_err", timeout_err, 0);
        chk("async_rst_timeout_ch", timeout_ch, 0);
        repeat (2) @(negedge clk);
        chk("rst_hold_timeout_err", timeout_err, 0);
        reset = 1'b0;
        guard = 0;
        while (!rd && guard < 40) begin @(negedge clk); guard++; end
        chk("post_reset_rd", rd, 1);
        chk("post_reset_first_port", sel, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
